// File: rtl/vram_pkg.sv
// Shared encodings for the VRAM port-A arbiter and the dpram-side blocks.
package vram_pkg;

    localparam int VRAM_ADDR_W = 16;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        ARB_FREE     = 2'd0,
        ARB_LOCK_CPU = 2'd1,
        ARB_LOCK_DMA = 2'd2
    } arb_st_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } own_e;

endpackage

// File: rtl/vram_arb.sv
// Round-robin arbiter for the CPU-side dpram port: CPU vs DMA, bounded locked
// bursts, registered RAM command and fixed two-cycle read-valid return.
//
//  state        | meaning
//  ARB_FREE     | no owner; ties go to the requester that is not last_q
//  ARB_LOCK_CPU | CPU holds a burst; keeps the port while bcnt_q < BURST_MAX
//  ARB_LOCK_DMA | DMA holds a burst; keeps the port while bcnt_q < BURST_MAX
module vram_arb
    import vram_pkg::*;
#(
    parameter int ADDR_W    = VRAM_ADDR_W,
    parameter int DATA_W    = VRAM_DATA_W,
    parameter int BURST_MAX = 8
) (
    input  logic              cpu_clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              dma_req,
    input  logic              cpu_lock,
    input  logic              dma_lock,
    input  logic              cpu_we,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              cpu_gnt,
    output logic              dma_gnt,
    output logic              cpu_rvalid,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              ram_wena,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [7:0] BMAX = 8'(BURST_MAX);

    arb_st_e           st_q, st_d;
    own_e              last_q, last_d;
    logic [7:0]        bcnt_q, bcnt_d;
    logic              wena_q, wena_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        cpu_rv_q, cpu_rv_d;
    logic [1:0]        dma_rv_q, dma_rv_d;

    logic    win_cpu, win_dma, win_lock;
    arb_st_e win_st;

    always_comb begin
        win_cpu = 1'b0;
        win_dma = 1'b0;
        case (st_q)
            ARB_LOCK_CPU: begin
                if (cpu_req && bcnt_q < BMAX) win_cpu = 1'b1;
                else if (dma_req)             win_dma = 1'b1;
                else                          win_cpu = cpu_req;
            end
            ARB_LOCK_DMA: begin
                if (dma_req && bcnt_q < BMAX) win_dma = 1'b1;
                else if (cpu_req)             win_cpu = 1'b1;
                else                          win_dma = dma_req;
            end
            default: begin
                if (cpu_req && dma_req) begin
                    win_cpu = (last_q == OWN_DMA);
                    win_dma = (last_q == OWN_CPU);
                end else begin
                    win_cpu = cpu_req;
                    win_dma = dma_req;
                end
            end
        endcase
        // Nothing may be accepted while reset is being sampled.
        if (!reset) begin
            win_cpu = 1'b0;
            win_dma = 1'b0;
        end
    end

    assign cpu_gnt = win_cpu;
    assign dma_gnt = win_dma;

    always_comb begin
        st_d     = st_q;
        last_d   = last_q;
        bcnt_d   = bcnt_q;
        wena_d   = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        win_lock = win_cpu ? cpu_lock : dma_lock;
        win_st   = win_cpu ? ARB_LOCK_CPU : ARB_LOCK_DMA;
        cpu_rv_d = {cpu_rv_q[0], win_cpu & ~cpu_we};
        dma_rv_d = {dma_rv_q[0], win_dma & ~dma_we};

        if (win_cpu || win_dma) begin
            last_d  = win_cpu ? OWN_CPU : OWN_DMA;
            wena_d  = win_cpu ? cpu_we : dma_we;
            addr_d  = win_cpu ? cpu_addr : dma_addr;
            wdata_d = win_cpu ? cpu_wdata : dma_wdata;
            if (win_lock) begin
                st_d = win_st;
                // Saturate so an unopposed burst can never wrap back below BMAX.
                if (st_q == win_st) bcnt_d = (bcnt_q == 8'hFF) ? bcnt_q : bcnt_q + 8'd1;
                else                bcnt_d = 8'd1;
            end else begin
                st_d   = ARB_FREE;
                bcnt_d = 8'd0;
            end
        end else if ((st_q == ARB_LOCK_CPU && !cpu_req) ||
                     (st_q == ARB_LOCK_DMA && !dma_req)) begin
            st_d   = ARB_FREE;
            bcnt_d = 8'd0;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!reset) begin
            st_q     <= ARB_FREE;
            last_q   <= OWN_DMA;
            bcnt_q   <= 8'd0;
            wena_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cpu_rv_q <= 2'b00;
            dma_rv_q <= 2'b00;
        end else begin
            st_q     <= st_d;
            last_q   <= last_d;
            bcnt_q   <= bcnt_d;
            wena_q   <= wena_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cpu_rv_q <= cpu_rv_d;
            dma_rv_q <= dma_rv_d;
        end
    end

    assign ram_wena   = wena_q;
    assign ram_addr   = addr_q;
    assign ram_wdata  = wdata_q;
    assign cpu_rvalid = cpu_rv_q[1];
    assign dma_rvalid = dma_rv_q[1];
    assign cpu_rdata  = ram_rdata;
    assign dma_rdata  = ram_rdata;

endmodule
